// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared widths, op encodings and FSM states for the shift unit.
// SHIFT_ROTATE_EN decides whether ROL/ROR count as legal ops.
package shift_pkg;

  localparam int DATA_W  = 32;
  localparam int SHAMT_W = 5;

  typedef enum logic [2:0] {
    OP_SLL = 3'b000,
    OP_SRL = 3'b001,
    OP_SRA = 3'b010,
    OP_ROL = 3'b011,
    OP_ROR = 3'b100
  } shift_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

  function automatic logic op_legal(input logic [2:0] op);
`ifdef SHIFT_ROTATE_EN
    return (op <= 3'b100);
`else
    return (op <= 3'b010);
`endif
  endfunction

endpackage

// File: rtl/shift_step.sv
// rtl/shift_step.sv - combinational single-bit shift/rotate of one value.
// Rotate paths exist only when SHIFT_ROTATE_EN is defined.
module shift_step
  import shift_pkg::*;
(
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] value,
  output logic [DATA_W-1:0] shifted
);

  always_comb begin
    shifted = value;
    case (op)
      OP_SLL:  shifted = {value[DATA_W-2:0], 1'b0};
      OP_SRL:  shifted = {1'b0, value[DATA_W-1:1]};
      OP_SRA:  shifted = {value[DATA_W-1], value[DATA_W-1:1]};
`ifdef SHIFT_ROTATE_EN
      OP_ROL:  shifted = {value[DATA_W-2:0], value[DATA_W-1]};
      OP_ROR:  shifted = {value[0], value[DATA_W-1:1]};
`endif
      default: shifted = value;
    endcase
  end

endmodule

// File: rtl/reg_desloc.sv
// rtl/reg_desloc.sv - multi-cycle shift register unit: FSM, step counter, result registers.
// Rotate ops are legal only when SHIFT_ROTATE_EN is defined.
module reg_desloc
  import shift_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [2:0]         op,
  input  logic [DATA_W-1:0]  data_in,
  input  logic [SHAMT_W-1:0] shamt,
  output logic [DATA_W-1:0]  data_out,
  output logic               busy,
  output logic               done,
  output logic               err
);

  state_e             state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [DATA_W-1:0]  step_out;

  shift_step u_step (
    .op      (op_q),
    .value   (data_q),
    .shifted (step_out)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          data_d  = data_in;
          cnt_d   = shamt;
          op_d    = op;
          busy_d  = 1'b1;
          state_d = op_legal(op) ? ST_SHIFT : ST_DONE;
        end
      end
      ST_SHIFT: begin
        if (cnt_q != '0) begin
          data_d = step_out;
          cnt_d  = cnt_q - 1'b1;
        end else begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
      ST_DONE: begin
        // Illegal ops enter DONE without a pulse yet; deliver it here so latency matches shamt=0.
        if (!done_q) begin
          done_d = 1'b1;
          err_d  = !op_legal(op_q);
          busy_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign data_out = data_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_reg_desloc.sv
// tb/tb_reg_desloc.sv - self-checking bench for reg_desloc against an arithmetic shift model.
// Define SHIFT_ROTATE_EN consistently for RTL and bench to exercise rotates.
module tb_reg_desloc;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] data_in;
  logic [4:0]  shamt;
  logic [31:0] data_out;
  logic        busy;
  logic        done;
  logic        err;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

`ifdef SHIFT_ROTATE_EN
  localparam bit ROT_EN = 1'b1;
`else
  localparam bit ROT_EN = 1'b0;
`endif

  reg_desloc dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .op       (op),
    .data_in  (data_in),
    .shamt    (shamt),
    .data_out (data_out),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit legal(input logic [2:0] o);
    return (o <= 3'd2) || (ROT_EN && (o == 3'd3 || o == 3'd4));
  endfunction

  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] d, input int n);
    if (!legal(o)) return d;
    case (o)
      3'd0: return d << n;
      3'd1: return d >> n;
      3'd2: return 32'($signed(d) >>> n);
      3'd3: return (n == 0) ? d : ((d << n) | (d >> (32 - n)));
      3'd4: return (n == 0) ? d : ((d >> n) | (d << (32 - n)));
      default: return d;
    endcase
  endfunction

  task automatic run_op(input logic [2:0] o, input logic [31:0] d, input logic [4:0] n,
                        input bit repulse);
    logic [31:0] exp_data;
    int          exp_lat;
    int          cyc;
    bit          seen;
    exp_data = model(o, d, int'(n));
    exp_lat  = legal(o) ? int'(n) + 1 : 1;
    @(negedge clk);
    start = 1'b1; op = o; data_in = d; shamt = n;
    @(posedge clk);
    #1;
    start = 1'b0; op = 3'($urandom); data_in = $urandom; shamt = 5'($urandom);
    @(negedge clk);
    chk("busy_after_accept", 32'(busy), 32'd1);
    chk("no_early_done", 32'(done), 32'd0);
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 40) begin
      if (repulse && cyc == 1) begin
        start = 1'b1; op = 3'd0; data_in = ~d; shamt = 5'd3;
      end
      @(posedge clk);
      cyc++;
      #1 start = 1'b0;
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("done_seen", 32'(seen), 32'd1);
    chk("latency", 32'(cyc), 32'(exp_lat));
    chk("data_out", data_out, exp_data);
    chk("err_at_done", 32'(err), 32'(!legal(o)));
    chk("busy_at_done", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("err_cleared", 32'(err), 32'd0);
    chk("data_held", data_out, exp_data);
    if (repulse) begin
      repeat (3) @(negedge clk);
      chk("no_queued_request", 32'({busy, done}), 32'd0);
      chk("data_after_repulse", data_out, exp_data);
    end
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; op = '0; data_in = '0; shamt = '0;
    repeat (2) @(negedge clk);
    chk("reset_data", data_out, 32'd0);
    chk("reset_flags", 32'({busy, done, err}), 32'd0);
    reset_n = 1'b1;

    run_op(3'd0, 32'h0000_0001, 5'd4,  1'b0);
    run_op(3'd2, 32'h8000_0000, 5'd31, 1'b0);
    run_op(3'd1, 32'h8000_0000, 5'd31, 1'b0);
    run_op(3'd1, 32'hF000_0000, 5'd0,  1'b0);
    run_op(3'd4, 32'h0000_0001, 5'd1,  1'b0);
    run_op(3'd3, 32'h8000_0001, 5'd2,  1'b0);
    run_op(3'd7, 32'h1234_5678, 5'd9,  1'b0);
    run_op(3'd0, 32'hA5A5_A5A5, 5'd8,  1'b1);

    // Abort an SLL by 10 partway through its shifting.
    @(negedge clk);
    start = 1'b1; op = 3'd0; data_in = 32'h0000_0003; shamt = 5'd10;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("midreset_data", data_out, 32'd0);
    chk("midreset_flags", 32'({busy, done, err}), 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("midreset_no_done", 32'(done), 32'd0);
    end
    reset_n = 1'b1;
    run_op(3'd0, 32'h0000_0003, 5'd10, 1'b0);

    for (int i = 0; i < 20; i++) begin
      run_op(3'($urandom_range(0, 7)), $urandom, 5'($urandom), 1'b0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/reg_desloc.md
REG_DESLOC -- requirements
Module: reg_desloc

Interface
REQ-001 SHALL provide `clk`, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL provide `reset_n`, input, 1, an asynchronous active-low reset.
REQ-003 SHALL provide `start`, input, 1, a shift request, sampled only in IDLE.
REQ-004 SHALL provide `op`, input, 3, the shift operation: 000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR; 101–111 are illegal.
REQ-005 SHALL provide `data_in`, input, 32, the operand (RegB/RegA value).
REQ-006 SHALL provide `shamt`, input, 5, the shift amount, driven by the upstream shift-amount select mux.
REQ-007 SHALL provide `data_out`, output, 32, the shift result register.
REQ-008 SHALL provide `busy`, output, 1, high from the cycle after start acceptance until done.
REQ-009 SHALL provide `done`, output, 1, a one-cycle completion pulse.
REQ-010 SHALL provide `err`, output, 1, an illegal-op flag, pulsed together with done.

Function
REQ-011 SHALL implement states IDLE, SHIFT and DONE.
REQ-012 IDLE with start=1 SHALL do all of the following:
- load data_out←data_in, cnt←shamt, latch op;
- go to SHIFT with busy=1;
- for an illegal op, go directly to DONE with err=1 and data_out=data_in.
REQ-013 IDLE with start=0 SHALL hold all outputs, with busy=0 and done=0.
REQ-014 SHIFT with cnt≠0 SHALL apply one 1-bit step of the latched op to data_out and decrement cnt.
REQ-015 SHIFT with cnt=0 SHALL go to DONE without modifying data_out.
REQ-016 DONE SHALL assert done for exactly one cycle, clear busy and return to IDLE.
REQ-017 For shamt=N, done SHALL be high N+1 cycles after the accepting edge, so N=0 completes in 1 cycle and N=31 in 32 cycles.
REQ-018 Step rules SHALL be:
- SLL shifts in 0 at bit 0;
- SRL shifts in 0 at bit 31;
- SRA replicates bit 31;
- ROL moves bit 31 to bit 0;
- ROR moves bit 0 to bit 31.
REQ-019 start while busy or in DONE SHALL be ignored, and no request SHALL be queued.
REQ-020 data_in, op and shamt changes after acceptance SHALL NOT affect the operation in progress.
REQ-021 data_out SHALL hold its final value from done until the next accepted start.
REQ-022 err SHALL be 0 whenever done is 0.

Reset
REQ-023 reset_n=0 SHALL immediately force state=IDLE, data_out=0, cnt=0, busy=0, done=0 and err=0.
REQ-024 A reset mid-SHIFT SHALL abort the operation with no done pulse.
REQ-025 After release, the first rising edge with start=1 SHALL be accepted normally.

Configuration
REQ-026 Macro SHIFT_ROTATE_EN defined: ROL and ROR SHALL operate per REQ-018.
REQ-027 Macro SHIFT_ROTATE_EN undefined: op 011 and 100 SHALL be illegal per REQ-012, and no rotate logic SHALL be synthesised.

Structure
REQ-028 Package shift_pkg SHALL hold the following shared items:
- the op encodings;
- the state enum;
- DATA_W=32 and SHAMT_W=5.
REQ-029 The upstream shift-amount mux SHALL import the same SHAMT_W constant from shift_pkg.
REQ-030 One-bit step logic SHALL be a combinational sub-module, shift_step, taking (op, value) and returning the shifted value.
REQ-031 reg_desloc SHALL contain the FSM, the counter and the output registers.

Verification
REQ-032 SLL, data_in 0x00000001, shamt 4 → done 5 cycles after accept, data_out 0x00000010, err 0.
REQ-033 SRA, data_in 0x80000000, shamt 31 → done after 32 cycles, data_out 0xFFFFFFFF; SRL with the same inputs → 0x00000001.
REQ-034 SRL, data_in 0xF0000000, shamt 0 → done after 1 cycle, data_out 0xF0000000.
REQ-035 ROR, data_in 0x00000001, shamt 1:
- with SHIFT_ROTATE_EN → 0x80000000, err 0;
- without it → done after 1 cycle, err 1, data_out 0x00000001.
REQ-036 start re-pulsed while busy → ignored, result unchanged; op 111 → err 1 with data_out=data_in.
REQ-037 reset_n low at cycle 3 of SLL shamt 10 → outputs 0 immediately, no done; next start accepted normally.
